// File: rtl/fir_tdm_mac_ctrl.sv
// fir_tdm_mac_ctrl: time-multiplexed controller for a 32-tap symmetric FIR.
// One pre-adder and one 13x12 multiplier are shared across the 16 folded tap
// pairs. Each rising edge of f_s shifts the delay line and runs a 16-step MAC,
// then saturates and scales the result by 1.5 onto dout.
// The coefficient bank is double buffered: writes go to the shadow bank and
// are copied to the active bank at the start of the next sample after a commit.
// Optional build macro: FIR_TDM_ROUND_EN (round-half-up before extraction).
module fir_tdm_mac_ctrl #(
    parameter int DW    = 12,
    parameter int CW    = 12,
    parameter int NPAIR = 16,
    parameter int AW    = 29
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 f_s,
    input  logic signed [DW-1:0] din,
    input  logic                 cf_we,
    input  logic [3:0]           cf_addr,
    input  logic signed [CW-1:0] cf_wdata,
    input  logic                 cf_commit,
    input  logic                 ovr_clr,
    output logic                 busy,
    output logic signed [DW-1:0] dout,
    output logic                 dout_vld,
    output logic                 overrun
);

    localparam int NTAP = 2 * NPAIR;
    localparam int KW   = $clog2(NPAIR);
    localparam int XW   = $clog2(NTAP);
    localparam int PW   = DW + 1 + CW;   // pre-add width times coefficient width
    localparam int SH   = 15;            // binary point of the accumulator
    localparam int HW   = AW - SH;       // accumulator bits above the binary point

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                 pl0, pl1;
    logic                 start;
    logic                 load, mac_en, out_en;
    logic [KW-1:0]        k;
    logic                 commit_pend;
    logic signed [DW-1:0] x      [NTAP];
    logic signed [CW-1:0] cf_act [NPAIR];
    logic signed [CW-1:0] cf_shd [NPAIR];
    logic signed [AW-1:0] acc;

    logic [XW-1:0]        xa_idx, xb_idx;
    logic signed [DW:0]   pre;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc_rnd;
    logic signed [HW-1:0] acc_hi;
    logic signed [DW-1:0] esum;
    logic signed [DW:0]   sum_adj;
    logic signed [DW-1:0] dout_sat;

    // Power-up low-pass coefficient set, used for both banks on reset.
    function automatic logic signed [CW-1:0] coef_init(input int unsigned idx);
        case (idx)
            0:       coef_init = CW'(35);
            1:       coef_init = CW'(58);
            2:       coef_init = CW'(103);
            3:       coef_init = CW'(164);
            4:       coef_init = CW'(245);
            5:       coef_init = CW'(345);
            6:       coef_init = CW'(463);
            7:       coef_init = CW'(596);
            8:       coef_init = CW'(741);
            9:       coef_init = CW'(891);
            10:      coef_init = CW'(1040);
            11:      coef_init = CW'(1181);
            12:      coef_init = CW'(1304);
            13:      coef_init = CW'(1404);
            14:      coef_init = CW'(1474);
            15:      coef_init = CW'(1511);
            default: coef_init = '0;
        endcase
    endfunction

    // Two-stage sampler on the strobe level; start marks its rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pl0 <= 1'b0;
            pl1 <= 1'b0;
        end else begin
            pl0 <= f_s;
            pl1 <= pl0;
        end
    end

    assign start = pl0 & ~pl1;
    assign busy  = (state != IDLE);

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Sequencer next state and per-phase enables.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        mac_en    = 1'b0;
        out_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (k == KW'(NPAIR - 1)) state_nxt = OUT;
            end
            OUT: begin
                out_en    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Folded tap pair k: pre-add the mirrored samples, then multiply.
    always_comb begin
        xa_idx = XW'(k);
        xb_idx = XW'(NTAP - 1) - xa_idx;
        pre    = (DW + 1)'(x[xa_idx]) + (DW + 1)'(x[xb_idx]);
        prod   = PW'(pre) * PW'(cf_act[k]);
    end

    // Delay line shift on sample start; accumulate one tap pair per MAC cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NTAP; i++) x[i] <= '0;
            acc <= '0;
            k   <= '0;
        end else if (load) begin
            x[0] <= din;
            for (int unsigned i = 1; i < NTAP; i++) x[i] <= x[i-1];
            acc <= '0;
            k   <= '0;
        end else if (mac_en) begin
            acc <= acc + AW'(prod);
            k   <= k + 1'b1;
        end
    end

    // Shadow bank takes writes any cycle; a pending commit copies it to the
    // active bank only at sample start, so the copy sees the pre-write value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NPAIR; i++) begin
                cf_shd[i] <= coef_init(i);
                cf_act[i] <= coef_init(i);
            end
            commit_pend <= 1'b0;
        end else begin
            if (cf_we) cf_shd[cf_addr] <= cf_wdata;
            if (load && commit_pend) begin
                for (int unsigned i = 0; i < NPAIR; i++) cf_act[i] <= cf_shd[i];
            end
            if (cf_commit)                commit_pend <= 1'b1;
            else if (load && commit_pend) commit_pend <= 1'b0;
        end
    end

`ifdef FIR_TDM_ROUND_EN
    assign acc_rnd = acc + AW'(1 << (SH - 1));
`else
    assign acc_rnd = acc;
`endif

    // Extract the 12-bit sum with range clamp, then scale by 1.5 and clamp again.
    always_comb begin
        acc_hi = HW'(acc_rnd >>> SH);
        if (acc_hi[HW-1:DW-1] == '0 || acc_hi[HW-1:DW-1] == '1)
            esum = acc_hi[DW-1:0];
        else if (acc_hi[HW-1])
            esum = {1'b1, {(DW-1){1'b0}}};
        else
            esum = {1'b0, {(DW-1){1'b1}}};

        sum_adj = (DW + 1)'(esum) + (DW + 1)'(esum >>> 1);
        if (sum_adj[DW] != sum_adj[DW-1])
            dout_sat = sum_adj[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            dout_sat = sum_adj[DW-1:0];
    end

    // Output register and its one-cycle valid pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout     <= '0;
            dout_vld <= 1'b0;
        end else begin
            dout_vld <= out_en;
            if (out_en) dout <= dout_sat;
        end
    end

    // Sticky overrun: a start seen while busy is dropped; set beats clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              overrun <= 1'b0;
        else if (start && busy) overrun <= 1'b1;
        else if (ovr_clr)      overrun <= 1'b0;
    end

endmodule

// File: tb/tb_fir_tdm_mac_ctrl.sv
// Directed testbench for fir_tdm_mac_ctrl (default build, truncation).
module tb_fir_tdm_mac_ctrl;

    logic              clk;
    logic              rst;
    logic              f_s;
    logic signed [11:0] din;
    logic              cf_we;
    logic [3:0]        cf_addr;
    logic signed [11:0] cf_wdata;
    logic              cf_commit;
    logic              ovr_clr;
    logic              busy;
    logic signed [11:0] dout;
    logic              dout_vld;
    logic              overrun;

    int n_cmp;
    int n_bad;

    fir_tdm_mac_ctrl #(.DW(12), .CW(12), .NPAIR(16), .AW(29)) dut (
        .clk      (clk),
        .rst      (rst),
        .f_s      (f_s),
        .din      (din),
        .cf_we    (cf_we),
        .cf_addr  (cf_addr),
        .cf_wdata (cf_wdata),
        .cf_commit(cf_commit),
        .ovr_clr  (ovr_clr),
        .busy     (busy),
        .dout     (dout),
        .dout_vld (dout_vld),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; f_s = 1'b0; din = '0; cf_we = 1'b0; cf_addr = '0;
        cf_wdata = '0; cf_commit = 1'b0; ovr_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // One 20-clock strobe period: returns last dout seen with dout_vld,
    // cycle index of the first pulse (posedges counted from f_s rise), pulse count.
    task automatic strobe(input logic signed [11:0] d, output logic signed [11:0] got,
                          output int lat, output int nvld);
        got = 'x; lat = -1; nvld = 0;
        @(negedge clk);
        din = d; f_s = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (dout_vld) begin
                nvld++;
                if (lat < 0) lat = i;
                got = dout;
            end
            if (i == 2) f_s = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        n_cmp++; if (dout !== 12'sd0) begin n_bad++; $display("FAIL rst_dout: got %0d expected 0", dout); end
        n_cmp++; if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL rst_vld: got %0b expected 0", dout_vld); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_ovr: got %0b expected 0", overrun); end
    endtask

    task automatic test_impulse();
        logic signed [11:0] got;
        int lat, nvld;
        do_reset();
        strobe(12'sd1000, got, lat, nvld);
        n_cmp++; if (got !== 12'sd1) begin n_bad++; $display("FAIL imp0_dout: got %0d expected 1", got); end
        n_cmp++; if (lat !== 19) begin n_bad++; $display("FAIL imp0_latency: got %0d expected 19", lat); end
        n_cmp++; if (nvld !== 1) begin n_bad++; $display("FAIL imp0_pulses: got %0d expected 1", nvld); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL imp0_busy: got %0b expected 0", busy); end
        strobe(12'sd0, got, lat, nvld);
        n_cmp++; if (got !== 12'sd1) begin n_bad++; $display("FAIL imp1_dout: got %0d expected 1", got); end
        n_cmp++; if (lat !== 19) begin n_bad++; $display("FAIL imp1_latency: got %0d expected 19", lat); end
        strobe(12'sd0, got, lat, nvld);
        n_cmp++; if (got !== 12'sd4) begin n_bad++; $display("FAIL imp2_dout: got %0d expected 4", got); end
        strobe(12'sd0, got, lat, nvld);
        n_cmp++; if (got !== 12'sd7) begin n_bad++; $display("FAIL imp3_dout: got %0d expected 7", got); end
    endtask

    task automatic test_dc_pos();
        logic signed [11:0] got;
        int lat, nvld;
        do_reset();
        strobe(12'sd2047, got, lat, nvld);
        n_cmp++; if (got !== 12'sd3) begin n_bad++; $display("FAIL dcp_first: got %0d expected 3", got); end
        for (int i = 1; i < 40; i++) strobe(12'sd2047, got, lat, nvld);
        n_cmp++; if (got !== 12'sd2047) begin n_bad++; $display("FAIL dcp_settled: got %0d expected 2047", got); end
    endtask

    task automatic test_dc_neg();
        logic signed [11:0] got;
        int lat, nvld;
        do_reset();
        strobe(-12'sd2048, got, lat, nvld);
        n_cmp++; if (got !== -12'sd5) begin n_bad++; $display("FAIL dcn_first: got %0d expected -5", got); end
        for (int i = 1; i < 40; i++) strobe(-12'sd2048, got, lat, nvld);
        n_cmp++; if (got !== -12'sd2048) begin n_bad++; $display("FAIL dcn_settled: got %0d expected -2048", got); end
    endtask

    task automatic test_overrun();
        logic signed [11:0] got;
        int lat, nvld;
        do_reset();
        got = 'x; lat = -1; nvld = 0;
        @(negedge clk);
        din = 12'sd1000; f_s = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (dout_vld) begin
                nvld++;
                if (lat < 0) lat = i;
                got = dout;
            end
            if (i == 2)  f_s = 1'b0;
            if (i == 10) begin din = 12'sd500; f_s = 1'b1; end
            if (i == 12) f_s = 1'b0;
        end
        n_cmp++; if (nvld !== 1) begin n_bad++; $display("FAIL ovr_pulses: got %0d expected 1", nvld); end
        n_cmp++; if (lat !== 19) begin n_bad++; $display("FAIL ovr_latency: got %0d expected 19", lat); end
        n_cmp++; if (got !== 12'sd1) begin n_bad++; $display("FAIL ovr_dout: got %0d expected 1", got); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag_set: got %0b expected 1", overrun); end
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_flag_clr: got %0b expected 0", overrun); end
        // dropped sample must not have entered the delay line
        strobe(12'sd0, got, lat, nvld);
        n_cmp++; if (got !== 12'sd1) begin n_bad++; $display("FAIL ovr_dline: got %0d expected 1", got); end
    endtask

    task automatic test_commit();
        logic signed [11:0] got;
        int lat, nvld;
        do_reset();
        got = 'x;
        @(negedge clk);
        din = 12'sd1000; f_s = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (dout_vld) got = dout;
            if (i == 2) f_s = 1'b0;
            if (i == 5) begin cf_we = 1'b1; cf_addr = 4'd0; cf_wdata = 12'sd2047; cf_commit = 1'b1; end
            if (i == 6) begin cf_we = 1'b0; cf_commit = 1'b0; end
        end
        n_cmp++; if (got !== 12'sd1) begin n_bad++; $display("FAIL cmt_current: got %0d expected 1", got); end
        for (int i = 0; i < 32; i++) strobe(12'sd0, got, lat, nvld);
        strobe(12'sd1000, got, lat, nvld);
        n_cmp++; if (got !== 12'sd93) begin n_bad++; $display("FAIL cmt_new_coef: got %0d expected 93", got); end
        strobe(12'sd0, got, lat, nvld);
        n_cmp++; if (got !== 12'sd1) begin n_bad++; $display("FAIL cmt_tap1: got %0d expected 1", got); end
    endtask

    task automatic test_reset_mid();
        logic signed [11:0] got;
        int lat, nvld;
        do_reset();
        @(negedge clk);
        cf_we = 1'b1; cf_addr = 4'd0; cf_wdata = 12'sd2047; cf_commit = 1'b1;
        @(negedge clk);
        cf_we = 1'b0; cf_commit = 1'b0;
        strobe(12'sd1000, got, lat, nvld);
        n_cmp++; if (got !== 12'sd93) begin n_bad++; $display("FAIL rmid_pre: got %0d expected 93", got); end
        @(negedge clk);
        din = 12'sd0; f_s = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 2) f_s = 1'b0;
        end
        rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %0b expected 0", busy); end
        n_cmp++; if (dout !== 12'sd0) begin n_bad++; $display("FAIL rmid_dout: got %0d expected 0", dout); end
        nvld = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (dout_vld) nvld++;
            if (i == 2) begin @(negedge clk); rst = 1'b1; end
        end
        n_cmp++; if (nvld !== 0) begin n_bad++; $display("FAIL rmid_no_vld: got %0d expected 0", nvld); end
        strobe(12'sd1000, got, lat, nvld);
        n_cmp++; if (got !== 12'sd1) begin n_bad++; $display("FAIL rmid_imp0: got %0d expected 1", got); end
        strobe(12'sd0, got, lat, nvld);
        n_cmp++; if (got !== 12'sd1) begin n_bad++; $display("FAIL rmid_imp1: got %0d expected 1", got); end
        strobe(12'sd0, got, lat, nvld);
        n_cmp++; if (got !== 12'sd4) begin n_bad++; $display("FAIL rmid_imp2: got %0d expected 4", got); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0; f_s = 1'b0; din = '0; cf_we = 1'b0; cf_addr = '0;
        cf_wdata = '0; cf_commit = 1'b0; ovr_clr = 1'b0;
        test_reset();
        test_impulse();
        test_dc_pos();
        test_dc_neg();
        test_overrun();
        test_commit();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
